dmem_responder: RTL and testbench

- Data-memory responder, i.e. the slave end of the CPU's 2-port DMEM interface (independent write port and read port).
- Backs the MA stage with a word-addressed storage array and a fixed 1-cycle registered read.
- Runs a reset-time clear sequencer so that every word reads 0 after reset.
- Used as the DMEM in CPU-level simulation and as the synthesizable scratchpad.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/dmem_array.sv | 41 ++++
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-level constants and types.
// Memory bus widths plus the DMEM responder state encoding.
package cpu_pkg;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_DATA_WIDTH = 32;

    typedef enum logic {
        DMEM_INIT,
        DMEM_RUN
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage for the DMEM responder: one write port, one registered read port.
// A same-index write and read in one cycle return the write data.
module dmem_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rzero,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            if (rzero) begin
                rdata <= '0;
            end else if (we && (widx == ridx)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[ridx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// DMEM slave: reset-time clear, range check, error pulse, 1-cycle reads.
// Optional access counters are built when DMEM_ACCESS_CNT_EN is defined.
import cpu_pkg::*;

module dmem_responder #(
    parameter int ADDR_W = MEM_ADDR_WIDTH,
    parameter int DATA_W = MEM_DATA_WIDTH,
    parameter int DEPTH  = 1024
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] Dmem_Waddr,
    input  logic [DATA_W-1:0] Dmem_Wdata,
    input  logic              Dmem_Wen,
    input  logic [ADDR_W-1:0] Dmem_Raddr,
    input  logic              Dmem_Ren,
    output logic [DATA_W-1:0] Dmem_Rdata,
    output logic              Init_Busy,
    output logic              Oor_Err
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0]       Rd_Cnt,
    output logic [31:0]       Wr_Cnt,
    output logic [15:0]       Err_Cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> IDX_W) == '0;
    endfunction

    dmem_state_t      state;
    dmem_state_t      state_nxt;
    logic [IDX_W-1:0] clr_ptr;
    logic [IDX_W-1:0] clr_ptr_nxt;

    logic run;
    logic wr_in;
    logic rd_in;
    logic wr_ok;
    logic rd_ok;
    logic err_nxt;

    logic              arr_we;
    logic [IDX_W-1:0]  arr_widx;
    logic [DATA_W-1:0] arr_wdata;

    assign run     = (state == DMEM_RUN);
    assign wr_in   = in_range(Dmem_Waddr);
    assign rd_in   = in_range(Dmem_Raddr);
    assign wr_ok   = run && Dmem_Wen && wr_in;
    assign rd_ok   = run && Dmem_Ren && rd_in;
    assign err_nxt = run && ((Dmem_Wen && !wr_in) ||
                             (Dmem_Ren && !rd_in));

    assign Init_Busy = !run;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= DMEM_INIT;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        unique case (state)
            DMEM_INIT: begin
                clr_ptr_nxt = clr_ptr + IDX_W'(1);
                if (clr_ptr == IDX_W'(DEPTH - 1)) begin
                    state_nxt = DMEM_RUN;
                end
            end
            DMEM_RUN: begin
                state_nxt = DMEM_RUN;
            end
            default: begin
                state_nxt = DMEM_INIT;
            end
        endcase
    end

    // The clear sequencer owns the write port until RUN.
    always_comb begin
        arr_we    = 1'b1;
        arr_widx  = clr_ptr;
        arr_wdata = '0;
        if (run) begin
            arr_we    = wr_ok;
            arr_widx  = Dmem_Waddr[IDX_W-1:0];
            arr_wdata = Dmem_Wdata;
        end
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (Clk),
        .rst_n (Rst_n),
        .we    (arr_we),
        .widx  (arr_widx),
        .wdata (arr_wdata),
        .re    (Dmem_Ren),
        .rzero (!rd_ok),
        .ridx  (Dmem_Raddr[IDX_W-1:0]),
        .rdata (Dmem_Rdata)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Oor_Err <= 1'b0;
        end else begin
            Oor_Err <= err_nxt;
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Rd_Cnt  <= '0;
            Wr_Cnt  <= '0;
            Err_Cnt <= '0;
        end else begin
            if (rd_ok) begin
                Rd_Cnt <= Rd_Cnt + 32'd1;
            end
            if (wr_ok) begin
                Wr_Cnt <= Wr_Cnt + 32'd1;
            end
            if (err_nxt && (Err_Cnt != 16'hFFFF)) begin
                Err_Cnt <= Err_Cnt + 16'd1;
            end
        end
    end
`else
    // Without counters the accept/error terms only feed the array and pulse.
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder at DEPTH=16: reference model plus read scoreboard.
// Counter checks are added when DMEM_ACCESS_CNT_EN is defined.
module tb_dmem_responder;
    import cpu_pkg::*;

    localparam int DEPTH = 16;
    localparam int IW    = $clog2(DEPTH);
    localparam int AW    = MEM_ADDR_WIDTH;
    localparam int DW    = MEM_DATA_WIDTH;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic [AW-1:0] Dmem_Waddr = '0;
    logic [DW-1:0] Dmem_Wdata = '0;
    logic          Dmem_Wen = 1'b0;
    logic [AW-1:0] Dmem_Raddr = '0;
    logic          Dmem_Ren = 1'b0;
    logic [DW-1:0] Dmem_Rdata;
    logic          Init_Busy;
    logic          Oor_Err;
`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0]   Rd_Cnt;
    logic [31:0]   Wr_Cnt;
    logic [15:0]   Err_Cnt;
`endif

    always #5 Clk = ~Clk;

    dmem_responder #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Dmem_Waddr (Dmem_Waddr),
        .Dmem_Wdata (Dmem_Wdata),
        .Dmem_Wen   (Dmem_Wen),
        .Dmem_Raddr (Dmem_Raddr),
        .Dmem_Ren   (Dmem_Ren),
        .Dmem_Rdata (Dmem_Rdata),
        .Init_Busy  (Init_Busy),
        .Oor_Err    (Oor_Err)
`ifdef DMEM_ACCESS_CNT_EN
        ,
        .Rd_Cnt     (Rd_Cnt),
        .Wr_Cnt     (Wr_Cnt),
        .Err_Cnt    (Err_Cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_rd;
    int            init_left;
    int            m_rd;
    int            m_wr;
    int            m_err;

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic          had_rd;
        logic          exp_err;
        logic          run;
        logic [DW-1:0] rv;
        run     = (init_left == 0);
        exp_err = 1'b0;
        had_rd  = Dmem_Ren;
        if (Dmem_Ren) begin
            rv = '0;
            if (run && Dmem_Raddr < DEPTH) begin
                if (Dmem_Wen && Dmem_Waddr == Dmem_Raddr)
                    rv = Dmem_Wdata;
                else
                    rv = model[Dmem_Raddr[IW-1:0]];
                m_rd++;
            end
            if (run && Dmem_Raddr >= DEPTH) exp_err = 1'b1;
            exp_q.push_back(rv);
        end
        if (Dmem_Wen && run) begin
            if (Dmem_Waddr < DEPTH) begin
                model[Dmem_Waddr[IW-1:0]] = Dmem_Wdata;
                m_wr++;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (exp_err) m_err++;
        @(posedge Clk);
        #1;
        if (init_left > 0) init_left--;
        if (had_rd) begin
            last_rd = exp_q.pop_front();
            check_eq("rdata", Dmem_Rdata, last_rd);
        end else begin
            check_eq("rdata_hold", Dmem_Rdata, last_rd);
        end
        check_eq("oor_err", {31'b0, Oor_Err}, {31'b0, exp_err});
        check_eq("init_busy", {31'b0, Init_Busy},
                 {31'b0, init_left != 0});
    endtask

    task automatic op(input logic          we,
                      input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd,
                      input logic          re,
                      input logic [AW-1:0] ra);
        Dmem_Wen   = we;
        Dmem_Waddr = wa;
        Dmem_Wdata = wd;
        Dmem_Ren   = re;
        Dmem_Raddr = ra;
        step();
        Dmem_Wen = 1'b0;
        Dmem_Ren = 1'b0;
    endtask

    task automatic do_reset();
        Dmem_Wen = 1'b0;
        Dmem_Ren = 1'b0;
        Rst_n    = 1'b0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        init_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_q.delete();
        last_rd = '0;
        m_rd  = 0;
        m_wr  = 0;
        m_err = 0;
        check_eq("rst_rdata", Dmem_Rdata, 32'h0);
        check_eq("rst_busy", {31'b0, Init_Busy}, 32'h1);
        check_eq("rst_oor", {31'b0, Oor_Err}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge Clk);
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) op(0, 0, 0, 0, 0);
        op(1, 0, 32'h55, 1, 0);
        for (int i = 0; i < DEPTH; i++) op(0, 0, 0, 1, AW'(i));

        op(1, 5, 32'hDEADBEEF, 0, 0);
        op(0, 0, 0, 1, 5);
        op(0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0);

        op(1, 3, 32'h12345678, 1, 3);
        op(0, 0, 0, 0, 0);

        op(1, 16, 32'hFF, 0, 0);
        op(0, 0, 0, 1, 0);
        op(0, 0, 0, 1, 32'h40);
        op(0, 0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            op(1'($urandom_range(0, 1)), AW'($urandom_range(0, 19)),
               DW'($urandom), 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 19)));
        end

        op(1, 7, 32'hA5, 0, 0);
        op(0, 0, 0, 1, 7);
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) op(0, 0, 0, 0, 0);
        op(1, 7, 32'hFFFF, 0, 0);
        op(0, 0, 0, 1, 7);

        op(1, 2, 32'h11, 0, 0);
        op(1, 9, 32'h22, 1, 2);
        op(1, 20, 32'h33, 1, 9);
        op(0, 0, 0, 0, 0);
`ifdef DMEM_ACCESS_CNT_EN
        check_eq("rd_cnt", Rd_Cnt, 32'(m_rd));
        check_eq("wr_cnt", Wr_Cnt, 32'(m_wr));
        check_eq("err_cnt", {16'b0, Err_Cnt}, 32'(m_err));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
